fan_duty_scheduler: RTL
=======================

Name: fan_duty_scheduler

Overview:
Sequencing controller for the two-fan cooling pair. It filters the raw temp36/temp38 threshold inputs and converts them to a demand level. It then schedules which fan runs, so wear is shared between the fans, minimum hold times are enforced, and a faulted fan is routed around. It sits between the temperature sensor comparators and the fan drivers, replacing direct decode of fan1/fan2 from the thresholds.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required before a synchronized temp input is accepted (min 1)
MIN_HOLD_CYCLES, 16, minimum cycles in a state before a downward (cooling) transition is allowed (min 1)
ROTATE_CYCLES, 32, run length in SINGLE before the active fan is swapped (FAN_ROTATE_EN only, min 2)

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
temp36  input  1  raw threshold flag, asynchronous to Clock
temp38  input  1  raw threshold flag, asynchronous to Clock
fan1_fault  input  1  fan1 tach fault, synchronous to Clock
fan2_fault  input  1  fan2 tach fault, synchronous to Clock
fan1  output  1  run fan1 (active-high)
fan2  output  1  run fan2 (active-high)
level  output  2  current state code: 0 IDLE, 1 SINGLE, 2 DUAL
alarm  output  1  both fans faulted

Behaviour:
- Reset (Resetn low, any time, including mid-run): state=IDLE, fan1=fan2=0, level=0, alarm=0, filtered temps=0, all counters=0, next_pick=0 (fan1), sel=0.
- Input filter, per temp input:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced value differs from the filtered value, and clears when they are equal.
  - When the counter reaches DEB_CYCLES-1 and the values still differ, the filtered value takes the synced value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never reaches the filtered value.
- Demand: t38_f=1 -> DUAL (regardless of t36_f); else t36_f=1 -> SINGLE; else IDLE.
- hold_cnt: clears on every state change; otherwise increments, saturating at MIN_HOLD_CYCLES-1. hold_done = (hold_cnt == MIN_HOLD_CYCLES-1).
- FSM transitions, evaluated every cycle:
  - Upward moves (IDLE->SINGLE, IDLE->DUAL, SINGLE->DUAL) happen immediately, ignoring hold.
  - Downward moves (DUAL->SINGLE, DUAL->IDLE, SINGLE->IDLE) happen only when hold_done=1. Otherwise the state holds.
- Fan selection:
  - On IDLE->SINGLE: sel<=next_pick and next_pick toggles. If the picked fan is faulted and the other is not, the other fan is used instead.
  - DUAL->SINGLE keeps the current sel.
- Outputs are decoded from registered state and are glitch-free:
  - IDLE: 00.
  - SINGLE: fan selected by sel.
  - DUAL: both fans.
  - A faulted fan's output is forced 0, unless both fans are faulted.
- Faults:
  - If the sel fan faults in SINGLE, sel switches to the other fan on the next edge and the rotate counter clears.
  - Both fans faulted: alarm=1, and fan1=fan2=1 in every state, including IDLE (fail-safe).
  - alarm deasserts the cycle after either fault clears.
- Latency from a raw temp edge to a fan output change: 2 + DEB_CYCLES + 1 cycles, plus any hold wait on downward moves.
- Counters are $clog2(param)+1 bits wide; there is no wrap past the terminal value.

Optional Feature:
FAN_ROTATE_EN
- Defined: a rotate counter runs in SINGLE. At ROTATE_CYCLES-1 it sets sel<=~sel and clears the counter. A rotation is skipped if the target fan is faulted. The counter clears on entry to SINGLE.
- Undefined: no rotate counter. sel changes only on IDLE->SINGLE entry or on a fault. ROTATE_CYCLES is ignored.

Decomposition:
- Package fan_ctrl_pkg: state enum (IDLE/SINGLE/DUAL, 2-bit, codes 0/1/2), fan-select constants FAN1=0/FAN2=1.
- Sub-module fan_debounce (synchronizer plus debounce counter, parameter DEB_CYCLES), instantiated once for temp36 and once for temp38.

Test Plan:
1. Reset, then temp36=1 held -> fan1=1, fan2=0, level=1 exactly 7 cycles after the edge. Drop temp36 -> return to IDLE no earlier than hold_done.
2. temp36 pulse of 3 cycles -> no output change, level stays 0.
3. temp36=1 then temp38=1 -> DUAL 7 cycles after the temp38 edge, with no hold wait. Drop temp38 -> SINGLE only after 16 cycles in DUAL, same fan as before.
4. Two IDLE->SINGLE episodes -> first drives fan1, second drives fan2. With FAN_ROTATE_EN, a continuous SINGLE run swaps fan every 32 cycles.
5. In SINGLE on fan1, assert fan1_fault -> next cycle fan1=0, fan2=1. Assert fan2_fault too -> alarm=1, fan1=fan2=1. Apply the same faults in IDLE -> both fans on.
6. Pulse Resetn low during DUAL -> immediately fan1=fan2=0, level=0, alarm=0. After release, the next SINGLE picks fan1.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Shared types for the two-fan duty scheduler: state encoding, fan identifiers
// and a small fault lookup helper.
package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    DUAL   = 2'd2
  } state_e;

  localparam logic FAN1 = 1'b0;
  localparam logic FAN2 = 1'b1;

  // Fault flag of the fan identified by 'which' (FAN1 or FAN2).
  function automatic logic fan_faulted(input logic which, input logic f1, input logic f2);
    return (which == FAN2) ? f2 : f1;
  endfunction

endpackage

// File: rtl/fan_debounce.sv
// Two-flop synchronizer followed by a stability filter: the filtered output only
// follows the synchronized input after DEB_CYCLES consecutive differing cycles.
module fan_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) filt_d = sync2_q;
      else                  cnt_d  = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/fan_duty_scheduler.sv
// Two-fan cooling scheduler: filtered temperature demand, hold-time limited FSM,
// alternating fan selection with fault routing. Optional macro FAN_ROTATE_EN
// adds periodic fan swapping during long SINGLE runs.
module fan_duty_scheduler
  import fan_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES      = 4,
  parameter int MIN_HOLD_CYCLES = 16,
  parameter int ROTATE_CYCLES   = 32
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       temp36,
  input  logic       temp38,
  input  logic       fan1_fault,
  input  logic       fan2_fault,
  output logic       fan1,
  output logic       fan2,
  output logic [1:0] level,
  output logic       alarm
);

  localparam int HW = $clog2(MIN_HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD_CYCLES - 1);

  logic          t36_f, t38_f;
  state_e        state_q, state_d, demand;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_done;
  logic          sel_q, sel_d;
  logic          next_pick_q, next_pick_d;
  logic          fan1_q, fan1_d, fan2_q, fan2_d, alarm_q, alarm_d;
  logic          run1, run2, both_f, fault_switch;

  fan_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb36 (
    .clk(Clock), .rst_n(Resetn), .raw_i(temp36), .filt_o(t36_f)
  );

  fan_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb38 (
    .clk(Clock), .rst_n(Resetn), .raw_i(temp38), .filt_o(t38_f)
  );

  assign demand    = t38_f ? DUAL : (t36_f ? SINGLE : IDLE);
  assign hold_done = (hold_cnt_q == HOLD_MAX);
  assign both_f    = fan1_fault & fan2_fault;

  // Upward moves are immediate; cooling moves wait for the hold counter.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = demand;
      SINGLE:  if (demand == DUAL || (demand == IDLE && hold_done)) state_d = demand;
      DUAL:    if (demand != DUAL && hold_done) state_d = demand;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) hold_cnt_d = '0;
    else if (!hold_done)    hold_cnt_d = hold_cnt_q + HW'(1);
  end

  // A running single fan that faults hands over to its partner if that one is healthy.
  assign fault_switch = (state_q != IDLE) && (state_d == SINGLE) &&
                        fan_faulted(sel_q, fan1_fault, fan2_fault) &&
                        !fan_faulted(~sel_q, fan1_fault, fan2_fault);

`ifdef FAN_ROTATE_EN
  localparam int RW = $clog2(ROTATE_CYCLES) + 1;
  localparam logic [RW-1:0] ROT_MAX = RW'(ROTATE_CYCLES - 1);

  logic [RW-1:0] rot_cnt_q, rot_cnt_d;
  logic          rot_due;

  assign rot_due = (state_q == SINGLE) && (state_d == SINGLE) && (rot_cnt_q == ROT_MAX);

  always_comb begin
    rot_cnt_d = '0;
    if (state_q == SINGLE && state_d == SINGLE && !fault_switch && !rot_due)
      rot_cnt_d = rot_cnt_q + RW'(1);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) rot_cnt_q <= '0;
    else         rot_cnt_q <= rot_cnt_d;
  end
`endif

  always_comb begin
    sel_d       = sel_q;
    next_pick_d = next_pick_q;
    if (state_q == IDLE && state_d == SINGLE) begin
      next_pick_d = ~next_pick_q;
      sel_d       = next_pick_q;
      if (fan_faulted(next_pick_q, fan1_fault, fan2_fault) &&
          !fan_faulted(~next_pick_q, fan1_fault, fan2_fault))
        sel_d = ~next_pick_q;
    end else if (fault_switch) begin
      sel_d = ~sel_q;
    end
`ifdef FAN_ROTATE_EN
    else if (rot_due && !fan_faulted(~sel_q, fan1_fault, fan2_fault)) begin
      sel_d = ~sel_q;
    end
`endif
  end

  // Outputs are computed from next-state values and registered, so they never glitch.
  always_comb begin
    run1 = 1'b0;
    run2 = 1'b0;
    unique case (state_d)
      SINGLE: begin
        run1 = (sel_d == FAN1);
        run2 = (sel_d == FAN2);
      end
      DUAL: begin
        run1 = 1'b1;
        run2 = 1'b1;
      end
      default: ;
    endcase
    fan1_d  = both_f | (run1 & ~fan1_fault);
    fan2_d  = both_f | (run2 & ~fan2_fault);
    alarm_d = both_f;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      sel_q       <= FAN1;
      next_pick_q <= FAN1;
      fan1_q      <= 1'b0;
      fan2_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sel_q       <= sel_d;
      next_pick_q <= next_pick_d;
      fan1_q      <= fan1_d;
      fan2_q      <= fan2_d;
      alarm_q     <= alarm_d;
    end
  end

  assign fan1  = fan1_q;
  assign fan2  = fan2_q;
  assign level = state_q;
  assign alarm = alarm_q;

endmodule
